// File: rtl/life_pkg.sv
// Shared definitions for the life pixel-domain blocks: bus widths,
// SRAM slot phase markers and the slot grant encoding.
package life_pkg;

  localparam int unsigned LIFE_ADDR_W = 19;
  localparam int unsigned LIFE_DATA_W = 8;

  // Slot phases within the 8-cycle window: read slot 0-3, write slot 4-7
  localparam logic [2:0] RD_START  = 3'd0;
  localparam logic [2:0] RD_SAMPLE = 3'd3;
  localparam logic [2:0] WR_START  = 3'd4;
  localparam logic [2:0] WE_FIRST  = 3'd5;
  localparam logic [2:0] WE_LAST   = 3'd6;
  localparam logic [2:0] WR_LAST   = 3'd7;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ENG  = 2'd1,
    CPU  = 2'd2
  } grant_t;

endpackage

// File: rtl/ram_slot_arbiter.sv
// Single-SRAM slot arbiter: an 8-cycle window split into a read slot and a
// write slot, shared between the life engine (priority) and CPU requests.
// All SRAM pins and requester returns are registered.
module ram_slot_arbiter
  import life_pkg::*;
#(
  parameter int unsigned ADDR_W = LIFE_ADDR_W,
  parameter int unsigned DATA_W = LIFE_DATA_W
) (
  input  logic              clk_pixel,
  input  logic              rst,
  input  logic              sync,
  input  logic              eng_active,
  input  logic              eng_wr_en,
  input  logic [ADDR_W-1:0] eng_rd_addr,
  input  logic [ADDR_W-1:0] eng_wr_addr,
  input  logic [DATA_W-1:0] eng_wr_data,
  output logic [DATA_W-1:0] eng_rd_data,
  output logic              eng_rd_valid,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cel,
  output logic              ram_oel,
  output logic              ram_wel,
  output logic [DATA_W-1:0] ram_dq_out,
  output logic              ram_dq_oe,
  input  logic [DATA_W-1:0] ram_dq_in
);

  logic [2:0]        ph, ph_d;
  grant_t            gnt, gnt_d;
  logic [ADDR_W-1:0] slot_addr, slot_addr_d;
  logic [DATA_W-1:0] slot_data, slot_data_d;
  logic              cpu_done;

  logic              live_d;
  logic              cel_d, oel_d, wel_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dq_d;
  logic              rd_done, wr_done;

  // State register: slot phase, current grant and the captured address/data
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      ph        <= RD_START;
      gnt       <= NONE;
      slot_addr <= '0;
      slot_data <= '0;
    end else begin
      ph        <= ph_d;
      gnt       <= gnt_d;
      slot_addr <= slot_addr_d;
      slot_data <= slot_data_d;
    end
  end

  // Next state: sync restarts the window (aborting any slot in flight);
  // grants are only decided at the two slot boundaries
  always_comb begin
    ph_d        = sync ? RD_START : ph + 3'd1;
    gnt_d       = gnt;
    slot_addr_d = slot_addr;
    slot_data_d = slot_data;
    if (ph_d == RD_START) begin
      if (eng_active) begin
        gnt_d       = ENG;
        slot_addr_d = eng_rd_addr;
      end else if (cpu_req && cpu_rnw && !cpu_done) begin
        gnt_d       = CPU;
        slot_addr_d = cpu_addr;
      end else begin
        gnt_d       = NONE;
      end
    end else if (ph_d == WR_START) begin
      if (eng_active && eng_wr_en) begin
        gnt_d       = ENG;
        slot_addr_d = eng_wr_addr;
        slot_data_d = eng_wr_data;
      end else if (cpu_req && !cpu_rnw && !cpu_done) begin
        gnt_d       = CPU;
        slot_addr_d = cpu_addr;
        slot_data_d = cpu_wdata;
      end else begin
        gnt_d       = NONE;
      end
    end
  end

  // Output decode: pin values for the coming cycle derived from next state,
  // so the pins are plain registers with no input-to-pin path
  always_comb begin
    live_d  = (gnt_d != NONE);
    cel_d   = !live_d;
    oel_d   = !(live_d && (ph_d < WR_START));
    wel_d   = !(live_d && (ph_d >= WE_FIRST) && (ph_d <= WE_LAST));
    addr_d  = live_d ? slot_addr_d : '1;
    dq_d    = (live_d && (ph_d >= WR_START)) ? slot_data_d : '0;
    // a sync on the sample edge aborts the read, so nothing is returned
    rd_done = (gnt != NONE) && (ph == RD_SAMPLE) && !sync;
    wr_done = (gnt == CPU) && (ph == WR_LAST);
  end

  // SRAM pin registers
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      ram_cel    <= 1'b1;
      ram_oel    <= 1'b1;
      ram_wel    <= 1'b1;
      ram_addr   <= '1;
      ram_dq_out <= '0;
      ram_dq_oe  <= 1'b0;
    end else begin
      ram_cel    <= cel_d;
      ram_oel    <= oel_d;
      ram_wel    <= wel_d;
      ram_addr   <= addr_d;
      ram_dq_out <= dq_d;
      ram_dq_oe  <= !wel_d;
    end
  end

  // Requester returns and the one-access-per-request latch
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      eng_rd_data  <= '0;
      eng_rd_valid <= 1'b0;
      cpu_rdata    <= '0;
      cpu_ack      <= 1'b0;
      cpu_done     <= 1'b0;
    end else begin
      eng_rd_valid <= 1'b0;
      cpu_ack      <= 1'b0;
      if (rd_done && (gnt == ENG)) begin
        eng_rd_data  <= ram_dq_in;
        eng_rd_valid <= 1'b1;
      end
      if (rd_done && (gnt == CPU)) begin
        cpu_rdata <= ram_dq_in;
        cpu_ack   <= 1'b1;
      end
      if (wr_done) begin
        cpu_ack <= 1'b1;
      end
      // set on the ack edge so the very next grant decision already sees it
      if ((rd_done && (gnt == CPU)) || wr_done) begin
        cpu_done <= 1'b1;
      end else if (!cpu_req) begin
        cpu_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Scoreboard bench for ram_slot_arbiter: expected SRAM accesses and
// requester returns are queued as stimulus is applied and retired by a
// negedge monitor against an independently tracked slot phase.
module tb_ram_slot_arbiter;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 8;

  logic          clk_pixel;
  logic          rst;
  logic          sync;
  logic          eng_active;
  logic          eng_wr_en;
  logic [AW-1:0] eng_rd_addr;
  logic [AW-1:0] eng_wr_addr;
  logic [DW-1:0] eng_wr_data;
  logic [DW-1:0] eng_rd_data;
  logic          eng_rd_valid;
  logic          cpu_req;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_cel;
  logic          ram_oel;
  logic          ram_wel;
  logic [DW-1:0] ram_dq_out;
  logic          ram_dq_oe;
  logic [DW-1:0] ram_dq_in;

  ram_slot_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_pixel    (clk_pixel),
    .rst          (rst),
    .sync         (sync),
    .eng_active   (eng_active),
    .eng_wr_en    (eng_wr_en),
    .eng_rd_addr  (eng_rd_addr),
    .eng_wr_addr  (eng_wr_addr),
    .eng_wr_data  (eng_wr_data),
    .eng_rd_data  (eng_rd_data),
    .eng_rd_valid (eng_rd_valid),
    .cpu_req      (cpu_req),
    .cpu_rnw      (cpu_rnw),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .ram_addr     (ram_addr),
    .ram_cel      (ram_cel),
    .ram_oel      (ram_oel),
    .ram_wel      (ram_wel),
    .ram_dq_out   (ram_dq_out),
    .ram_dq_oe    (ram_dq_oe),
    .ram_dq_in    (ram_dq_in)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  typedef struct packed {
    logic          is_rd;
    logic [DW-1:0] data;
  } ack_t;

  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] eng_q[$];
  acc_t          wr_q[$];
  ack_t          cpu_q[$];

  logic [AW-1:0] cur_rd_addr;
  acc_t          cur_wr;
  ack_t          cur_ack;
  logic [DW-1:0] cur_eng;
  logic [2:0]    tb_ph;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference slot phase: wraps mod 8, sync restarts the window
  always @(posedge clk_pixel or posedge rst) begin
    if (rst) tb_ph <= 3'd0;
    else     tb_ph <= sync ? 3'd0 : tb_ph + 3'd1;
  end

  // Monitor: every observed access or return must match a queued expectation
  always @(negedge clk_pixel) begin
    if (!rst) begin
      if (!ram_oel) begin
        check("oel_phase", 32'(tb_ph < 3'd4), 32'h1);
        check("oel_cel", 32'(ram_cel), 32'h0);
        if (tb_ph == 3'd0) begin
          check("rd_pending", 32'(rd_q.size() != 0), 32'h1);
          if (rd_q.size() != 0) begin
            cur_rd_addr = rd_q.pop_front();
            check("rd_addr", 32'(ram_addr), 32'(cur_rd_addr));
          end
        end
        if (tb_ph == 3'd3) check("rd_addr_hold", 32'(ram_addr), 32'(cur_rd_addr));
      end
      if (!ram_wel) begin
        check("wel_phase", 32'((tb_ph == 3'd5) || (tb_ph == 3'd6)), 32'h1);
        check("wel_dq_oe", 32'(ram_dq_oe), 32'h1);
        check("wel_oel", 32'(ram_oel), 32'h1);
        check("wel_cel", 32'(ram_cel), 32'h0);
        if (tb_ph == 3'd5) begin
          check("wr_pending", 32'(wr_q.size() != 0), 32'h1);
          if (wr_q.size() != 0) cur_wr = wr_q.pop_front();
        end
        check("wr_addr", 32'(ram_addr), 32'(cur_wr.addr));
        check("wr_data", 32'(ram_dq_out), 32'(cur_wr.data));
      end
      if (eng_rd_valid) begin
        check("eng_valid_ph", 32'(tb_ph), 32'h4);
        check("eng_pending", 32'(eng_q.size() != 0), 32'h1);
        if (eng_q.size() != 0) begin
          cur_eng = eng_q.pop_front();
          check("eng_rd_data", 32'(eng_rd_data), 32'(cur_eng));
        end
      end
      if (cpu_ack) begin
        check("cpu_ack_pending", 32'(cpu_q.size() != 0), 32'h1);
        if (cpu_q.size() != 0) begin
          cur_ack = cpu_q.pop_front();
          if (cur_ack.is_rd) begin
            check("cpu_rd_ack_ph", 32'(tb_ph), 32'h4);
            check("cpu_rdata", 32'(cpu_rdata), 32'(cur_ack.data));
          end else begin
            check("cpu_wr_ack_ph", 32'(tb_ph), 32'h0);
          end
        end
      end
    end
  end

  task automatic wait_ph(input logic [2:0] n);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk_pixel);
      if (tb_ph == n) found = 1'b1;
    end
    check("wait_ph", 32'(found), 32'h1);
  endtask

  task automatic wait_cpu_drain(input int budget);
    for (int i = 0; i < budget && cpu_q.size() != 0; i++) @(negedge clk_pixel);
    check("cpu_ack_seen", 32'(cpu_q.size()), 32'h0);
  endtask

  task automatic check_idle();
    check("idle_cel", 32'(ram_cel), 32'h1);
    check("idle_oel", 32'(ram_oel), 32'h1);
    check("idle_wel", 32'(ram_wel), 32'h1);
    check("idle_addr", 32'(ram_addr), 32'h7FFFF);
    check("idle_dq_oe", 32'(ram_dq_oe), 32'h0);
  endtask

  // Apply one engine window starting at the next ph=0
  task automatic eng_window(input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input logic [DW-1:0] dq,
                            input logic wr_en, input bit disturb);
    wait_ph(3'd7);
    eng_active  = 1'b1;
    eng_wr_en   = wr_en;
    eng_rd_addr = ra;
    eng_wr_addr = wa;
    eng_wr_data = wd;
    ram_dq_in   = dq;
    rd_q.push_back(ra);
    eng_q.push_back(dq);
    if (wr_en) wr_q.push_back('{wa, wd});
    if (disturb) begin
      wait_ph(3'd1);
      eng_rd_addr = ~ra;
      wait_ph(3'd4);
      eng_wr_addr = ~wa;
      eng_wr_data = ~wd;
    end
  endtask

  initial begin
    rst = 1'b1;
    sync = 1'b0;
    eng_active = 1'b0;
    eng_wr_en = 1'b0;
    eng_rd_addr = '0;
    eng_wr_addr = '0;
    eng_wr_data = '0;
    cpu_req = 1'b0;
    cpu_rnw = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    ram_dq_in = '0;
    cur_rd_addr = '0;
    cur_wr = '0;
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check_idle();
    rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_pixel);
      check_idle();
      check("idle_valid", 32'(eng_rd_valid), 32'h0);
      check("idle_ack", 32'(cpu_ack), 32'h0);
    end

    // engine read/write windows, second one with mid-slot input changes
    eng_window(19'h00010, 19'h0000E, 8'hA5, 8'h3C, 1'b1, 1'b0);
    eng_window(19'h20000, 19'h7FFFE, 8'h5A, 8'hC3, 1'b1, 1'b1);
    wait_ph(3'd7);
    eng_active = 1'b0;
    eng_wr_en  = 1'b0;
    repeat (10) @(negedge clk_pixel);
    check("eng_q_drained", 32'(eng_q.size()), 32'h0);

    // CPU read in blanking, request held well past the ack
    wait_ph(3'd2);
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 19'h12345; ram_dq_in = 8'h5A;
    rd_q.push_back(19'h12345);
    cpu_q.push_back('{1'b1, 8'h5A});
    wait_cpu_drain(24);
    repeat (24) @(negedge clk_pixel);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk_pixel);

    // CPU write blocked by engine writes, served once eng_wr_en drops
    eng_window(19'h00100, 19'h00101, 8'h11, 8'h22, 1'b1, 1'b0);
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 19'h7FF00; cpu_wdata = 8'h99;
    eng_window(19'h00102, 19'h00103, 8'h33, 8'h44, 1'b1, 1'b0);
    eng_window(19'h00104, 19'h00105, 8'h55, 8'h66, 1'b0, 1'b0);
    wr_q.push_back('{19'h7FF00, 8'h99});
    cpu_q.push_back('{1'b0, 8'h00});
    wait_ph(3'd7);
    eng_active = 1'b0;
    wait_cpu_drain(16);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk_pixel);

    // sync during ph=5 aborts the write; it re-runs in the realigned window
    wait_ph(3'd2);
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 19'h00ABC; cpu_wdata = 8'h3E;
    wr_q.push_back('{19'h00ABC, 8'h3E});
    wr_q.push_back('{19'h00ABC, 8'h3E});
    cpu_q.push_back('{1'b0, 8'h00});
    wait_ph(3'd5);
    check("pre_abort_wel", 32'(ram_wel), 32'h0);
    sync = 1'b1;
    @(negedge clk_pixel);
    sync = 1'b0;
    check("abort_wel", 32'(ram_wel), 32'h1);
    check("abort_dq_oe", 32'(ram_dq_oe), 32'h0);
    check("abort_cel", 32'(ram_cel), 32'h1);
    check("abort_ack", 32'(cpu_ack), 32'h0);
    wait_cpu_drain(24);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk_pixel);

    // reset asserted in the middle of a write pulse
    wait_ph(3'd2);
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 19'h00555; cpu_wdata = 8'h77;
    wr_q.push_back('{19'h00555, 8'h77});
    wait_ph(3'd5);
    #2;
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("rst_wel", 32'(ram_wel), 32'h1);
    check("rst_dq_oe", 32'(ram_dq_oe), 32'h0);
    check("rst_cel", 32'(ram_cel), 32'h1);
    check("rst_addr", 32'(ram_addr), 32'h7FFFF);
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    rst = 1'b0;
    repeat (24) @(negedge clk_pixel);
    check_idle();

    check("rd_q_left", 32'(rd_q.size()), 32'h0);
    check("wr_q_left", 32'(wr_q.size()), 32'h0);
    check("eng_q_left", 32'(eng_q.size()), 32'h0);
    check("cpu_q_left", 32'(cpu_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
